// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: lets the I-cache miss path and the D-cache miss/write
// path share one main-memory port. It sequences block refills and
// single-word write-throughs, and it drives the global pipeline stall (hit).
//
// Ports:
//   Clk, Rst                        clock and synchronous active-high reset
//   iReq, iAddr                     I-side refill request and byte address
//   dReq, dWe, dAddr, dWData        D-side request (dWe=1 write-through)
//   memAddr/memRead/memWrite/memWData/memRData/memReady  main-memory port
//   fillData, fillIdx               refill word and its index in the block
//   iFillValid, dFillValid          owner of fillData (one-cycle strobes)
//   iDone, dDone                    one-cycle transaction-complete pulses
//   hit                             combinational; 0 stalls the pipeline
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the grant
// when both sides request together. By default D has fixed priority over I.
module mem_refill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned IDX_W           = 2,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [31:0]       dWData,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRead,
  output logic              memWrite,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  input  logic              memReady,
  output logic [31:0]       fillData,
  output logic [IDX_W-1:0]  fillIdx,
  output logic              iFillValid,
  output logic              dFillValid,
  output logic              iDone,
  output logic              dDone,
  output logic              hit
);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_e;

  localparam logic [ADDR_W-1:0] BLK_MASK  = ~((ADDR_W'(1) << (IDX_W + 2)) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        fill_data_q, fill_data_d;
  logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
  logic               i_fill_valid_q, i_fill_valid_d;
  logic               d_fill_valid_q, d_fill_valid_d;
  logic               i_done_q, i_done_d;
  logic               d_done_q, d_done_d;
  logic               grant_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic               last_grant_q, last_grant_d;  // 1 = last grant went to I
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    idx_d          = idx_q;
    mem_addr_d     = mem_addr_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_wdata_d    = mem_wdata_q;
    fill_data_d    = fill_data_q;
    fill_idx_d     = fill_idx_q;
    i_fill_valid_d = 1'b0;
    d_fill_valid_d = 1'b0;
    i_done_d       = 1'b0;
    d_done_d       = 1'b0;
    grant_i        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d   = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        // A Done pulse means the requester has not yet dropped its request
        if (!(i_done_q || d_done_q) && (iReq || dReq)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          grant_i      = iReq && (!dReq || !last_grant_q);
          last_grant_d = grant_i;
`else
          grant_i      = iReq && !dReq;
`endif
          idx_d = '0;
          if (grant_i) begin
            state_d    = I_FILL;
            base_d     = iAddr & BLK_MASK;
            mem_addr_d = iAddr & BLK_MASK;
            mem_read_d = 1'b1;
          end else if (dWe) begin
            state_d     = D_WRITE;
            mem_addr_d  = dAddr & WORD_MASK;
            mem_wdata_d = dWData;
            mem_write_d = 1'b1;
          end else begin
            state_d    = D_FILL;
            base_d     = dAddr & BLK_MASK;
            mem_addr_d = dAddr & BLK_MASK;
            mem_read_d = 1'b1;
          end
        end
      end

      I_FILL, D_FILL: begin
        if (mem_read_q) begin
          if (memReady) begin
            mem_read_d     = 1'b0;
            fill_data_d    = memRData;
            fill_idx_d     = idx_q;
            i_fill_valid_d = (state_q == I_FILL);
            d_fill_valid_d = (state_q == D_FILL);
            if (idx_q == LAST_IDX) begin
              state_d  = IDLE;
              i_done_d = (state_q == I_FILL);
              d_done_d = (state_q == D_FILL);
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else begin
          // Gap cycle between words: re-strobe at the next word address
          mem_read_d = 1'b1;
          mem_addr_d = base_q + ADDR_W'({idx_q, 2'b00});
        end
      end

      D_WRITE: begin
        if (memReady) begin
          mem_write_d = 1'b0;
          d_done_d    = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= IDLE;
      base_q         <= '0;
      idx_q          <= '0;
      mem_addr_q     <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_wdata_q    <= '0;
      fill_data_q    <= '0;
      fill_idx_q     <= '0;
      i_fill_valid_q <= 1'b0;
      d_fill_valid_q <= 1'b0;
      i_done_q       <= 1'b0;
      d_done_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      idx_q          <= idx_d;
      mem_addr_q     <= mem_addr_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_wdata_q    <= mem_wdata_d;
      fill_data_q    <= fill_data_d;
      fill_idx_q     <= fill_idx_d;
      i_fill_valid_q <= i_fill_valid_d;
      d_fill_valid_q <= d_fill_valid_d;
      i_done_q       <= i_done_d;
      d_done_q       <= d_done_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign memAddr    = mem_addr_q;
  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;
  assign memWData   = mem_wdata_q;
  assign fillData   = fill_data_q;
  assign fillIdx    = fill_idx_q;
  assign iFillValid = i_fill_valid_q;
  assign dFillValid = d_fill_valid_q;
  assign iDone      = i_done_q;
  assign dDone      = d_done_q;

  // A request raised in IDLE stalls the pipeline in the same cycle
  assign hit = (state_q == IDLE) && !iReq && !dReq;

endmodule
